// File: rtl/datapath_multiciclo.sv
// Multi-cycle MIPS-subset core: one shared ALU, five-state control FSM, internal
// register file, and req/ack handshakes to external instruction and data memories.
module datapath_multiciclo #(
    parameter int              WIDTH    = 32,
    parameter int              REG_ADDR = 5,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             inclk,
    input  logic             rst,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic [WIDTH-1:0] dmem_addr,
    output logic [WIDTH-1:0] dmem_wdata,
    input  logic             dmem_ack,
    input  logic [WIDTH-1:0] dmem_rdata,
    output logic [WIDTH-1:0] pc,
    output logic [2:0]       state,
    output logic             halted
);
    localparam int NREGS = 1 << REG_ADDR;
    localparam logic [WIDTH-1:0] FOUR = WIDTH'(4);

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;
    localparam logic [5:0] OP_HALT = 6'h3F;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_SLT = 6'h2A;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd7
    } state_t;

    state_t            state_reg, state_next;
    logic [WIDTH-1:0]  pc_reg, pc_next;
    logic [31:0]       ir_reg, ir_next;
    logic [WIDTH-1:0]  a_reg, a_next;
    logic [WIDTH-1:0]  b_reg, b_next;
    logic [WIDTH-1:0]  alu_out_reg, alu_out_next;
    logic [WIDTH-1:0]  mdr_reg, mdr_next;
    logic [WIDTH-1:0]  regs_reg [NREGS];

    logic                rf_we;
    logic [REG_ADDR-1:0] rf_waddr;
    logic [WIDTH-1:0]    rf_wdata;

    logic [5:0]          op, funct;
    logic [REG_ADDR-1:0] rs, rt, rd;
    logic [15:0]         imm16;
    logic [25:0]         imm26;
    logic [WIDTH-1:0]    sext_imm, jump_target, branch_target;
    logic [WIDTH-1:0]    rs_val, rt_val, alu_b, alu_result;
    logic                is_r, funct_ok;

    assign op    = ir_reg[31:26];
    assign funct = ir_reg[5:0];
    assign rs    = ir_reg[21 +: REG_ADDR];
    assign rt    = ir_reg[16 +: REG_ADDR];
    assign rd    = ir_reg[11 +: REG_ADDR];
    assign imm16 = ir_reg[15:0];
    assign imm26 = ir_reg[25:0];
    assign is_r  = (op == OP_R);
    assign funct_ok = (funct == F_ADD) || (funct == F_SUB) || (funct == F_AND) ||
                      (funct == F_OR)  || (funct == F_SLT);

    generate
        if (WIDTH > 16) begin : g_sext_wide
            assign sext_imm = {{(WIDTH-16){imm16[15]}}, imm16};
        end else begin : g_sext_narrow
            assign sext_imm = imm16;
        end
        // Narrow cores have no pc bits above bit 27, so the jump target is just imm26<<2 truncated.
        if (WIDTH > 28) begin : g_jump_wide
            assign jump_target = {pc_reg[WIDTH-1:28], imm26, 2'b00};
        end else begin : g_jump_narrow
            logic [27:0] jt28;
            assign jt28        = {imm26, 2'b00};
            assign jump_target = jt28[WIDTH-1:0];
        end
    endgenerate

    // In DECODE pc_reg already holds pc+4.
    assign branch_target = pc_reg + (sext_imm << 2);
    assign rs_val = (rs == '0) ? '0 : regs_reg[rs];
    assign rt_val = (rt == '0) ? '0 : regs_reg[rt];

    always_comb begin
        alu_b      = is_r ? b_reg : sext_imm;
        alu_result = a_reg + alu_b;
        if (is_r) begin
            case (funct)
                F_SUB:   alu_result = a_reg - alu_b;
                F_AND:   alu_result = a_reg & alu_b;
                F_OR:    alu_result = a_reg | alu_b;
                F_SLT:   alu_result = {{(WIDTH-1){1'b0}}, ($signed(a_reg) < $signed(alu_b))};
                default: alu_result = a_reg + alu_b;
            endcase
        end
    end

    always_comb begin
        state_next   = state_reg;
        pc_next      = pc_reg;
        ir_next      = ir_reg;
        a_next       = a_reg;
        b_next       = b_reg;
        alu_out_next = alu_out_reg;
        mdr_next     = mdr_reg;
        rf_we        = 1'b0;
        rf_waddr     = '0;
        rf_wdata     = '0;
        case (state_reg)
            S_FETCH: begin
                if (imem_ack) begin
                    ir_next    = imem_rdata;
                    pc_next    = pc_reg + FOUR;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                a_next = rs_val;
                b_next = rt_val;
                case (op)
                    OP_J: begin
                        pc_next    = jump_target;
                        state_next = S_FETCH;
                    end
                    OP_BEQ: begin
                        if (rs_val == rt_val) pc_next = branch_target;
                        state_next = S_FETCH;
                    end
                    OP_HALT:                 state_next = S_HALT;
                    OP_R:                    state_next = funct_ok ? S_EXEC : S_FETCH;
                    OP_LW, OP_SW, OP_ADDI:   state_next = S_EXEC;
                    default:                 state_next = S_FETCH;
                endcase
            end
            S_EXEC: begin
                alu_out_next = alu_result;
                state_next   = (op == OP_LW || op == OP_SW) ? S_MEM : S_WB;
            end
            S_MEM: begin
                if (dmem_ack) begin
                    if (op == OP_LW) begin
                        mdr_next   = dmem_rdata;
                        state_next = S_WB;
                    end else begin
                        state_next = S_FETCH;
                    end
                end
            end
            S_WB: begin
                rf_we      = 1'b1;
                rf_waddr   = is_r ? rd : rt;
                rf_wdata   = (op == OP_LW) ? mdr_reg : alu_out_reg;
                state_next = S_FETCH;
            end
            S_HALT:  state_next = S_HALT;
            default: state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge inclk or posedge rst) begin
        if (rst) begin
            state_reg   <= S_FETCH;
            pc_reg      <= RESET_PC;
            ir_reg      <= '0;
            a_reg       <= '0;
            b_reg       <= '0;
            alu_out_reg <= '0;
            mdr_reg     <= '0;
        end else begin
            state_reg   <= state_next;
            pc_reg      <= pc_next;
            ir_reg      <= ir_next;
            a_reg       <= a_next;
            b_reg       <= b_next;
            alu_out_reg <= alu_out_next;
            mdr_reg     <= mdr_next;
        end
    end

    always_ff @(posedge inclk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NREGS; i++) regs_reg[i] <= '0;
        end else if (rf_we && rf_waddr != '0) begin
            regs_reg[rf_waddr] <= rf_wdata;
        end
    end

    // The fetch request is suppressed while reset is held so a dropped access is visible at once.
    assign imem_req   = (state_reg == S_FETCH) && !rst;
    assign imem_addr  = pc_reg;
    assign dmem_req   = (state_reg == S_MEM);
    assign dmem_we    = (state_reg == S_MEM) && (op == OP_SW);
    assign dmem_addr  = alu_out_reg;
    assign dmem_wdata = b_reg;
    assign pc         = pc_reg;
    assign state      = state_reg;
    assign halted     = (state_reg == S_HALT);
endmodule

// File: tb/tb_datapath_multiciclo.sv
// Directed bench: a 32-bit core running an ALU/memory/branch program with stalling
// memories, and a 16-bit core checking wrap-around, register aliasing and RESET_PC.
module tb_datapath_multiciclo;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, rst1;
    int   ntests = 0;
    int   nfail  = 0;
    int   cyc    = 0;

    logic        i0_req, i0_ack, d0_req, d0_we, d0_ack, h0;
    logic [31:0] i0_addr, i0_rdata, d0_addr, d0_wdata, d0_rdata, pc0;
    logic [2:0]  st0;
    logic        i1_req, i1_ack, d1_req, d1_we, d1_ack, h1;
    logic [15:0] i1_addr, d1_addr, d1_wdata, d1_rdata, pc1;
    logic [31:0] i1_rdata;
    logic [2:0]  st1;

    logic [31:0] imem0 [128];
    logic [31:0] dmem0 [64];
    logic [31:0] imem1 [128];
    logic [15:0] dmem1 [64];

    int ilat0 = 3;
    int icnt0 = 0;
    int dcnt0 = 0;

    assign i0_rdata = imem0[i0_addr[8:2]];
    assign d0_rdata = dmem0[d0_addr[7:2]];
    assign i0_ack   = i0_req && (icnt0 == ilat0);
    assign d0_ack   = d0_req && (dcnt0 == (d0_we ? 0 : 2));
    assign i1_rdata = imem1[i1_addr[8:2]];
    assign d1_rdata = dmem1[d1_addr[7:2]];
    assign i1_ack   = i1_req;
    assign d1_ack   = d1_req;

    datapath_multiciclo dut0 (
        .inclk(clk), .rst(rst),
        .imem_req(i0_req), .imem_addr(i0_addr), .imem_ack(i0_ack), .imem_rdata(i0_rdata),
        .dmem_req(d0_req), .dmem_we(d0_we), .dmem_addr(d0_addr), .dmem_wdata(d0_wdata),
        .dmem_ack(d0_ack), .dmem_rdata(d0_rdata),
        .pc(pc0), .state(st0), .halted(h0)
    );

    datapath_multiciclo #(.WIDTH(16), .REG_ADDR(3), .RESET_PC(16'h0100)) dut1 (
        .inclk(clk), .rst(rst1),
        .imem_req(i1_req), .imem_addr(i1_addr), .imem_ack(i1_ack), .imem_rdata(i1_rdata),
        .dmem_req(d1_req), .dmem_we(d1_we), .dmem_addr(d1_addr), .dmem_wdata(d1_wdata),
        .dmem_ack(d1_ack), .dmem_rdata(d1_rdata),
        .pc(pc1), .state(st1), .halted(h1)
    );

    always @(posedge clk) begin
        icnt0 <= (i0_req && !i0_ack) ? icnt0 + 1 : 0;
        dcnt0 <= (d0_req && !d0_ack) ? dcnt0 + 1 : 0;
    end

    logic [31:0] f0_pc [32];
    int          f0_cyc [32];
    logic [31:0] s0_a [32], s0_d [32];
    logic [15:0] f1_pc [32], s1_a [32], s1_d [32];
    int nf0 = 0, ns0 = 0, nl0 = 0, nreq0 = 0, nf1 = 0, ns1 = 0;

    always @(posedge clk) begin
        if (i0_req && i0_ack && nf0 < 32) begin
            f0_pc[nf0] = i0_addr; f0_cyc[nf0] = cyc; nf0++;
        end
        if (d0_req && d0_ack) begin
            if (d0_we) begin
                dmem0[d0_addr[7:2]] = d0_wdata;
                if (ns0 < 32) begin s0_a[ns0] = d0_addr; s0_d[ns0] = d0_wdata; ns0++; end
            end else nl0++;
        end
        if (i0_req || d0_req) nreq0++;
        if (i1_req && i1_ack && nf1 < 32) begin f1_pc[nf1] = i1_addr; nf1++; end
        if (d1_req && d1_ack && d1_we) begin
            dmem1[d1_addr[7:2]] = d1_wdata;
            if (ns1 < 32) begin s1_a[ns1] = d1_addr; s1_d[ns1] = d1_wdata; ns1++; end
        end
        cyc++;
    end

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt,
                                          input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction
    function automatic logic [31:0] enc_r(input int rs, input int rt, input int rd,
                                          input logic [5:0] funct);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'h00, funct};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    logic [31:0] exp_pc [23] = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h1C, 32'h20, 32'h24,
                                 32'h28, 32'h2C, 32'h30, 32'h34, 32'h38, 32'h3C, 32'h40, 32'h44,
                                 32'h48, 32'h4C, 32'h50, 32'h54, 32'h58, 32'h5C, 32'h100};
    int exp_len [22] = '{4, 4, 4, 4, 2, 2, 4, 4, 4, 4, 2, 4, 7, 4, 4, 4, 4, 4, 4, 4, 4, 2};
    logic [31:0] exp_sa [9] = '{32'h08, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h20, 32'h24, 32'h28, 32'h2C};
    logic [31:0] exp_sd [9] = '{32'h5, 32'h2, 32'hFFFFFFF8, 32'h1, 32'h5, 32'hFFFFFFFD, 32'h5,
                                32'h0, 32'h0};

    initial begin
        int snap;
        for (int i = 0; i < 128; i++) begin imem0[i] = '0; imem1[i] = '0; end
        for (int i = 0; i < 64; i++) begin dmem0[i] = '0; dmem1[i] = '0; end
        imem0[0]  = enc_i(6'h08, 0, 1, 16'd5);
        imem0[1]  = enc_i(6'h08, 0, 2, 16'hFFFD);
        imem0[2]  = enc_r(1, 2, 3, 6'h20);
        imem0[3]  = enc_r(2, 1, 4, 6'h22);
        imem0[4]  = enc_i(6'h04, 1, 1, 16'd2);
        imem0[5]  = enc_i(6'h08, 0, 10, 16'd1);
        imem0[6]  = enc_i(6'h08, 0, 10, 16'd1);
        imem0[7]  = enc_i(6'h04, 1, 2, 16'd5);
        imem0[8]  = enc_r(2, 1, 5, 6'h2A);
        imem0[9]  = enc_r(1, 2, 6, 6'h24);
        imem0[10] = enc_r(1, 2, 7, 6'h25);
        imem0[11] = enc_i(6'h08, 0, 0, 16'd7);
        imem0[12] = enc_i(6'h11, 1, 1, 16'h1234);
        imem0[13] = enc_i(6'h2B, 0, 1, 16'h08);
        imem0[14] = enc_i(6'h23, 0, 8, 16'h08);
        imem0[15] = enc_i(6'h2B, 0, 3, 16'h10);
        imem0[16] = enc_i(6'h2B, 0, 4, 16'h14);
        imem0[17] = enc_i(6'h2B, 0, 5, 16'h18);
        imem0[18] = enc_i(6'h2B, 0, 6, 16'h1C);
        imem0[19] = enc_i(6'h2B, 0, 7, 16'h20);
        imem0[20] = enc_i(6'h2B, 0, 8, 16'h24);
        imem0[21] = enc_i(6'h2B, 0, 0, 16'h28);
        imem0[22] = enc_i(6'h2B, 0, 10, 16'h2C);
        imem0[23] = {6'h02, 26'h40};
        imem0[24] = enc_i(6'h08, 0, 10, 16'd9);
        imem0[64] = 32'hFC00_0000;

        imem1[64] = enc_i(6'h08, 0, 1, 16'h7FFF);
        imem1[65] = enc_i(6'h08, 1, 1, 16'h0001);
        imem1[66] = enc_i(6'h2B, 0, 1, 16'h0004);
        imem1[67] = enc_i(6'h08, 0, 2, 16'h0003);
        imem1[68] = enc_r(2, 0, 9, 6'h20);
        imem1[69] = enc_i(6'h2B, 0, 9, 16'h0008);
        imem1[70] = 32'hFC00_0000;

        rst = 1'b1; rst1 = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("first_req", {31'b0, i0_req}, 32'd1);
        check("first_state", {29'b0, st0}, 32'd0);
        rst = 1'b1;
        #1;
        check("rst_imem_req", {31'b0, i0_req}, 32'd0);
        check("rst_dmem_req", {30'b0, d0_req, d0_we}, 32'd0);
        check("rst_pc", pc0, 32'd0);
        check("rst_halted", {28'b0, h0, st0}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("wait_req", {28'b0, i0_req, st0}, 32'h8);
        @(negedge clk);
        @(negedge clk);
        check("pc_before_ack", pc0, 32'd0);
        check("state_before_ack", {29'b0, st0}, 32'd0);
        @(negedge clk);
        check("pc_after_ack", pc0, 32'd4);
        check("state_after_ack", {29'b0, st0}, 32'd1);
        ilat0 = 0;

        for (int i = 0; i < 2000 && !h0; i++) @(negedge clk);
        check("halt0_reached", {31'b0, h0}, 32'd1);
        check("halt0_state", {29'b0, st0}, 32'd7);
        check("halt0_pc", pc0, 32'h104);
        check("fetch_count", nf0, 32'd23);
        for (int i = 0; i < 23 && i < nf0; i++) check($sformatf("fetch_pc%0d", i), f0_pc[i], exp_pc[i]);
        for (int i = 0; i < 22 && i + 1 < nf0; i++)
            check($sformatf("cycles_pc%h", exp_pc[i]), f0_cyc[i+1] - f0_cyc[i], exp_len[i]);
        check("store_count", ns0, 32'd9);
        check("load_count", nl0, 32'd1);
        for (int i = 0; i < 9 && i < ns0; i++) begin
            check($sformatf("store%0d_addr", i), s0_a[i], exp_sa[i]);
            check($sformatf("store%0d_data", i), s0_d[i], exp_sd[i]);
        end

        snap = nreq0;
        repeat (20) @(negedge clk);
        check("halt_no_reqs", nreq0 - snap, 32'd0);
        check("halt_stays", {28'b0, h0, st0}, 32'hF);

        rst = 1'b1;
        #1;
        check("restart_rst", {27'b0, i0_req, h0, st0}, 32'd0);
        check("restart_pc", pc0, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("restart_req", {31'b0, i0_req}, 32'd1);
        @(negedge clk);
        check("restart_pc4", pc0, 32'd4);

        rst1 = 1'b0;
        #1;
        check("w16_reset_pc", {16'b0, pc1}, 32'h100);
        for (int i = 0; i < 500 && !h1; i++) @(negedge clk);
        check("w16_halted", {28'b0, h1, st1}, 32'hF);
        check("w16_pc", {16'b0, pc1}, 32'h11C);
        check("w16_fetches", nf1, 32'd7);
        check("w16_first_fetch", {16'b0, f1_pc[0]}, 32'h100);
        check("w16_stores", ns1, 32'd2);
        check("w16_wrap_addr", {16'b0, s1_a[0]}, 32'h4);
        check("w16_wrap_data", {16'b0, s1_d[0]}, 32'h8000);
        check("w16_alias_addr", {16'b0, s1_a[1]}, 32'h8);
        check("w16_alias_data", {16'b0, s1_d[1]}, 32'h3);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
